// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong blocks (paddle, ball, renderer).
//   - Default playfield geometry and paddle step size.
//   - Paddle FSM state encoding and paddle direction encoding.
// No ports: this is a package imported with "import pong_pkg::*;".
// ---------------------------------------------------------------------------
package pong_pkg;

   // Default geometry shared by every block that draws or moves on the field
   localparam int SCREEN_H_DEF = 480;
   localparam int PADDLE_H_DEF = 64;
   localparam int STEP_DEF     = 8;

   // Paddle button FSM: first press, waiting for auto-repeat, auto-repeating
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } paddle_state_e;

   // Paddle movement direction; Up is the reset direction
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } paddle_dir_e;

endpackage

// File: rtl/paddle_repeat_timer.sv
// ---------------------------------------------------------------------------
// paddle_repeat_timer
// Hold-time counter for paddle auto-repeat. Counts up while enabled, clears
// on request, and flags the terminal count of whichever limit is selected.
// Ports:
//   clock    in  rising-edge clock
//   reset    in  synchronous active-high reset (counter to 0)
//   clear    in  counter to 0 on the next edge (wins over enable)
//   enable   in  increment the counter on the next edge
//   sel_rate in  0: compare against REPEAT_DLY-1, 1: against REPEAT_RATE-1
//   done     out counter is at the selected terminal count (combinational)
// ---------------------------------------------------------------------------
module paddle_repeat_timer #(
   parameter int REPEAT_DLY  = 12500000,
   parameter int REPEAT_RATE = 2500000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic sel_rate,
   output logic done
);

   // The counter never has to hold more than max(limit)-1
   localparam int MAX_LIM = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int CW      = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
   localparam logic [CW-1:0] DLY_TC  = CW'(REPEAT_DLY - 1);
   localparam logic [CW-1:0] RATE_TC = CW'(REPEAT_RATE - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear has priority so a step and a restart happen together
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == (sel_rate ? RATE_TC : DLY_TC));

endmodule

// File: rtl/paddle_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_ctrl
// Moves the paddle up/down from two debounced buttons, one step per press,
// with optional hold-to-repeat. The paddle is clamped to the playfield.
// Configuration macro: PADDLE_AUTOREPEAT_EN
//   defined   -> IDLE/DELAY/REPEAT auto-repeat using paddle_repeat_timer
//   undefined -> one step per press; a held button waits for release
// Ports:
//   CLOCK     in   sole clock, rising edge
//   Reset     in   synchronous active-high reset, highest priority
//   UpBtn     in   "up" button level
//   DownBtn   in   "down" button level
//   Freeze    in   hold position, force FSM to IDLE
//   PaddleY   out  [9:0] paddle top row, 0..SCREEN_H-PADDLE_H
//   MovePulse out  high for the one cycle PaddleY shows a new value
//   AtTop     out  PaddleY == 0
//   AtBottom  out  PaddleY == SCREEN_H-PADDLE_H
// ---------------------------------------------------------------------------
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int SCREEN_H    = SCREEN_H_DEF,
   parameter int PADDLE_H    = PADDLE_H_DEF,
   parameter int STEP        = STEP_DEF,
   parameter int REPEAT_DLY  = 12500000,
   parameter int REPEAT_RATE = 2500000
) (
   input  logic       CLOCK,
   input  logic       Reset,
   input  logic       UpBtn,
   input  logic       DownBtn,
   input  logic       Freeze,
   output logic [9:0] PaddleY,
   output logic       MovePulse,
   output logic       AtTop,
   output logic       AtBottom
);

   localparam int MAX_Y_I = SCREEN_H - PADDLE_H;
   localparam logic [9:0]  MAX_Y    = 10'(MAX_Y_I);
   localparam logic [10:0] MAX_Y_W  = 11'(MAX_Y_I);
   localparam logic [9:0]  CENTRE_Y = 10'(MAX_Y_I / 2);
   localparam logic [9:0]  STEP_V   = 10'(STEP);

   logic        req_up;
   logic        req_dn;
   logic        req_any;
   paddle_dir_e req_dir;

   logic [9:0]  y_q;
   logic [9:0]  y_d;
   logic        pulse_q;
   logic        pulse_d;

   logic [10:0] down_sum;
   logic [9:0]  up_y;
   logic [9:0]  down_y;
   logic        do_step;
   paddle_dir_e step_dir;

   // Both buttons together cancel out and count as no request
   assign req_up  = UpBtn & ~DownBtn;
   assign req_dn  = DownBtn & ~UpBtn;
   assign req_any = req_up | req_dn;
   assign req_dir = req_dn ? DIR_DOWN : DIR_UP;

   // Clamped step targets; the down sum carries an extra bit so it cannot wrap
   assign up_y     = (y_q < STEP_V) ? '0 : (y_q - STEP_V);
   assign down_sum = {1'b0, y_q} + {1'b0, STEP_V};
   assign down_y   = (down_sum > MAX_Y_W) ? MAX_Y : down_sum[9:0];

   // Position update; the pulse only fires if the clamped step really moved
   always_comb begin
      y_d = y_q;
      if (do_step) begin
         y_d = (step_dir == DIR_DOWN) ? down_y : up_y;
      end
      pulse_d = (y_d != y_q);
   end

`ifdef PADDLE_AUTOREPEAT_EN

   paddle_state_e state_q;
   paddle_state_e state_d;
   paddle_dir_e   dir_q;
   paddle_dir_e   dir_d;
   logic          tmr_clear;
   logic          tmr_en;
   logic          tmr_sel_rate;
   logic          tmr_done;
   logic          same_req;

   assign same_req     = req_any && (req_dir == dir_q);
   assign tmr_sel_rate = (state_q == ST_REPEAT);

   // Button FSM: step on a fresh press, then again after the initial hold
   // delay and at the repeat rate while the same button stays the only one
   // pressed. Any other request drops back to IDLE without stepping, so a
   // direction change costs one idle cycle.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      do_step   = 1'b0;
      step_dir  = dir_q;
      if (Freeze) begin
         state_d   = ST_IDLE;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_any) begin
                  do_step   = 1'b1;
                  step_dir  = req_dir;
                  dir_d     = req_dir;
                  tmr_clear = 1'b1;
                  state_d   = ST_DELAY;
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (!same_req) begin
                  state_d   = ST_IDLE;
                  tmr_clear = 1'b1;
               end else if (tmr_done) begin
                  do_step   = 1'b1;
                  tmr_clear = 1'b1;
                  state_d   = ST_REPEAT;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               tmr_clear = 1'b1;
            end
         endcase
      end
   end

   paddle_repeat_timer #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE)
   ) u_timer (
      .clock   (CLOCK),
      .reset   (Reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .sel_rate(tmr_sel_rate),
      .done    (tmr_done)
   );

   // State, direction, position and pulse registers
   always_ff @(posedge CLOCK) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         y_q     <= CENTRE_Y;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         y_q     <= y_d;
         pulse_q <= pulse_d;
      end
   end

`else

   logic held_q;
   logic held_d;

   // One step per press: held_q remembers that the current press has been
   // served and is only released once no request is active (or by Freeze)
   always_comb begin
      held_d   = held_q;
      do_step  = 1'b0;
      step_dir = req_dir;
      if (Freeze || !req_any) begin
         held_d = 1'b0;
      end else if (!held_q) begin
         do_step = 1'b1;
         held_d  = 1'b1;
      end
   end

   // Press-tracking, position and pulse registers
   always_ff @(posedge CLOCK) begin
      if (Reset) begin
         held_q  <= 1'b0;
         y_q     <= CENTRE_Y;
         pulse_q <= 1'b0;
      end else begin
         held_q  <= held_d;
         y_q     <= y_d;
         pulse_q <= pulse_d;
      end
   end

`endif

   assign PaddleY   = y_q;
   assign MovePulse = pulse_q;
   assign AtTop     = (y_q == '0);
   assign AtBottom  = (y_q == MAX_Y);

endmodule

// File: tb/tb_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddle_ctrl
// Directed bench for paddle_ctrl with a small playfield: SCREEN_H=64,
// PADDLE_H=16, STEP=4, REPEAT_DLY=4, REPEAT_RATE=2 (range 0..48, centre 24).
// Expectations follow PADDLE_AUTOREPEAT_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_paddle_ctrl;

   logic       CLOCK = 1'b0;
   logic       Reset;
   logic       UpBtn;
   logic       DownBtn;
   logic       Freeze;
   logic [9:0] PaddleY;
   logic       MovePulse;
   logic       AtTop;
   logic       AtBottom;

   int checks = 0;
   int errors = 0;

   paddle_ctrl #(
      .SCREEN_H   (64),
      .PADDLE_H   (16),
      .STEP       (4),
      .REPEAT_DLY (4),
      .REPEAT_RATE(2)
   ) dut (
      .CLOCK    (CLOCK),
      .Reset    (Reset),
      .UpBtn    (UpBtn),
      .DownBtn  (DownBtn),
      .Freeze   (Freeze),
      .PaddleY  (PaddleY),
      .MovePulse(MovePulse),
      .AtTop    (AtTop),
      .AtBottom (AtBottom)
   );

   // 10 ns clock
   always #5 CLOCK = ~CLOCK;

   // Advance one edge and settle; outputs are read 1 ns after the edge
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Two reset edges with every button released
   task automatic applyStimulus();
      Reset   = 1'b1;
      UpBtn   = 1'b0;
      DownBtn = 1'b0;
      Freeze  = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   // Reset state: centred, no pulse, at neither limit
   task automatic test_reset();
      applyStimulus();
      checks++;
      if (PaddleY !== 10'd24) begin
         errors++;
         $display("[TB] FAIL reset_y: got %0d expected 24", PaddleY);
      end
      checks++;
      if (MovePulse !== 1'b0 || AtTop !== 1'b0 || AtBottom !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got pulse=%b top=%b bot=%b expected 0 0 0",
                  MovePulse, AtTop, AtBottom);
      end
   endtask

   // One-cycle Up press: single step 24->20, one pulse, then nothing
   task automatic test_single_pulse();
      applyStimulus();
      UpBtn = 1'b1;
      tick();
      checks++;
      if (PaddleY !== 10'd20 || MovePulse !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pulse_step: got y=%0d pulse=%b expected y=20 pulse=1",
                  PaddleY, MovePulse);
      end
      UpBtn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (PaddleY !== 10'd20 || MovePulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pulse_idle%0d: got y=%0d pulse=%b expected y=20 pulse=0",
                     i, PaddleY, MovePulse);
         end
      end
   endtask

   // Up held 20 cycles: steps at cycles 1,5,7,9,... with auto-repeat,
   // only at cycle 1 without it
   task automatic test_hold_up();
      int   exp_y;
      logic step;
      logic exp_pulse;
      applyStimulus();
      exp_y = 24;
      UpBtn = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
`ifdef PADDLE_AUTOREPEAT_EN
         step = (i == 1) || (i >= 5 && (i % 2) == 1);
`else
         step = (i == 1);
`endif
         exp_pulse = step && (exp_y > 0);
         if (step) exp_y = (exp_y < 4) ? 0 : exp_y - 4;
         checks++;
         if (PaddleY !== 10'(exp_y) || MovePulse !== exp_pulse) begin
            errors++;
            $display("[TB] FAIL hold_up_c%0d: got y=%0d pulse=%b expected y=%0d pulse=%b",
                     i, PaddleY, MovePulse, exp_y, exp_pulse);
         end
      end
      checks++;
      if (AtTop !== (exp_y == 0)) begin
         errors++;
         $display("[TB] FAIL hold_up_top: got %b expected %b", AtTop, (exp_y == 0));
      end
      UpBtn = 1'b0;
      tick();
   endtask

   // Repeated Up presses down to 0; the extra press must not wrap or pulse
   task automatic test_top_clamp();
      int exp_y;
      applyStimulus();
      for (int k = 1; k <= 7; k++) begin
         UpBtn = 1'b1;
         tick();
         exp_y = (24 - 4 * k < 0) ? 0 : 24 - 4 * k;
         checks++;
         if (PaddleY !== 10'(exp_y) || MovePulse !== (k <= 6)) begin
            errors++;
            $display("[TB] FAIL top_press%0d: got y=%0d pulse=%b expected y=%0d pulse=%b",
                     k, PaddleY, MovePulse, exp_y, (k <= 6));
         end
         UpBtn = 1'b0;
         tick();
      end
      checks++;
      if (AtTop !== 1'b1 || AtBottom !== 1'b0) begin
         errors++;
         $display("[TB] FAIL top_flags: got top=%b bot=%b expected 1 0", AtTop, AtBottom);
      end
   endtask

   // Repeated Down presses up to 48; the extra press is clamped, no pulse
   task automatic test_bottom_clamp();
      int exp_y;
      applyStimulus();
      for (int k = 1; k <= 7; k++) begin
         DownBtn = 1'b1;
         tick();
         exp_y = (24 + 4 * k > 48) ? 48 : 24 + 4 * k;
         checks++;
         if (PaddleY !== 10'(exp_y) || MovePulse !== (k <= 6)) begin
            errors++;
            $display("[TB] FAIL bot_press%0d: got y=%0d pulse=%b expected y=%0d pulse=%b",
                     k, PaddleY, MovePulse, exp_y, (k <= 6));
         end
         DownBtn = 1'b0;
         tick();
      end
      checks++;
      if (AtBottom !== 1'b1 || AtTop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bot_flags: got bot=%b top=%b expected 1 0", AtBottom, AtTop);
      end
   endtask

   // Both buttons cancel; Freeze blocks a held Down; releasing Freeze with
   // Down still held is a fresh press
   task automatic test_both_and_freeze();
      applyStimulus();
      UpBtn   = 1'b1;
      DownBtn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (PaddleY !== 10'd24 || MovePulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_c%0d: got y=%0d pulse=%b expected y=24 pulse=0",
                     i, PaddleY, MovePulse);
         end
      end
      UpBtn  = 1'b0;
      Freeze = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (PaddleY !== 10'd24 || MovePulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL freeze_c%0d: got y=%0d pulse=%b expected y=24 pulse=0",
                     i, PaddleY, MovePulse);
         end
      end
      Freeze = 1'b0;
      tick();
      checks++;
      if (PaddleY !== 10'd28 || MovePulse !== 1'b1) begin
         errors++;
         $display("[TB] FAIL unfreeze: got y=%0d pulse=%b expected y=28 pulse=1",
                  PaddleY, MovePulse);
      end
      DownBtn = 1'b0;
      tick();
   endtask

   // Up then straight to Down: one idle cycle before the new direction
   // steps with auto-repeat; without it the held press just waits
   task automatic test_direction_change();
      int exp_y2;
`ifdef PADDLE_AUTOREPEAT_EN
      exp_y2 = 24;
`else
      exp_y2 = 20;
`endif
      applyStimulus();
      UpBtn = 1'b1;
      tick();
      tick();
      UpBtn   = 1'b0;
      DownBtn = 1'b1;
      tick();
      checks++;
      if (PaddleY !== 10'd20 || MovePulse !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dirchg_gap: got y=%0d pulse=%b expected y=20 pulse=0",
                  PaddleY, MovePulse);
      end
      tick();
      checks++;
      if (PaddleY !== 10'(exp_y2) || MovePulse !== (exp_y2 != 20)) begin
         errors++;
         $display("[TB] FAIL dirchg_step: got y=%0d pulse=%b expected y=%0d pulse=%b",
                  PaddleY, MovePulse, exp_y2, (exp_y2 != 20));
      end
      DownBtn = 1'b0;
      tick();
   endtask

   // Reset in the middle of a held Down (REPEAT with auto-repeat) recentres;
   // the still-held button then steps again as a new press
   task automatic test_reset_abort();
      int exp_y8;
`ifdef PADDLE_AUTOREPEAT_EN
      exp_y8 = 36;
`else
      exp_y8 = 28;
`endif
      applyStimulus();
      DownBtn = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (PaddleY !== 10'(exp_y8)) begin
         errors++;
         $display("[TB] FAIL abort_pre: got y=%0d expected %0d", PaddleY, exp_y8);
      end
      Reset = 1'b1;
      tick();
      checks++;
      if (PaddleY !== 10'd24 || MovePulse !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_reset: got y=%0d pulse=%b expected y=24 pulse=0",
                  PaddleY, MovePulse);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (PaddleY !== 10'd28 || MovePulse !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_repress: got y=%0d pulse=%b expected y=28 pulse=1",
                  PaddleY, MovePulse);
      end
      tick();
      checks++;
      if (PaddleY !== 10'd28 || MovePulse !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_hold: got y=%0d pulse=%b expected y=28 pulse=0",
                  PaddleY, MovePulse);
      end
      DownBtn = 1'b0;
      tick();
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_single_pulse();
      test_hold_up();
      test_top_clamp();
      test_bottom_clamp();
      test_both_and_freeze();
      test_direction_change();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
